// File: rtl/radix4_booth_mult_param_pkg.sv
// Shared types and width helper for the iterative radix-4 Booth multiplier.
package radix4_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIN
  } state_t;

  typedef enum logic [2:0] {
    ZERO,
    POS1,
    POS2,
    NEG1,
    NEG2
  } booth_digit_t;

  // One guard bit above the operand lets unsigned values look positive to the
  // signed Booth recoding; rounding up to even keeps whole digit pairs.
  function automatic int even_ext_width(input int w);
    return ((w + 1) % 2 == 0) ? (w + 1) : (w + 2);
  endfunction

endpackage

// File: rtl/radix4_booth_mult_param_encoder.sv
// Radix-4 Booth recoder: turns a multiplier bit triplet into d*A_ext, d in {-2..+2}.
module booth_r4_encoder
  import radix4_pkg::*;
#(
  parameter int EW = 10
) (
  input  logic [2:0]    i_triplet,
  input  logic [EW-1:0] i_a_ext,
  output logic [EW+1:0] o_pp
);

  logic [EW+1:0] w_a1;
  logic [EW+1:0] w_a2;
  booth_digit_t  w_digit;

  assign w_a1 = {{2{i_a_ext[EW-1]}}, i_a_ext};
  assign w_a2 = {i_a_ext[EW-1], i_a_ext, 1'b0};

  always_comb begin
    w_digit = ZERO;
    case (i_triplet)
      3'b001, 3'b010: w_digit = POS1;
      3'b011:         w_digit = POS2;
      3'b100:         w_digit = NEG2;
      3'b101, 3'b110: w_digit = NEG1;
      default:        w_digit = ZERO;
    endcase
  end

  // EW+2 bits so that -2 * (most negative A_ext) still fits.
  always_comb begin
    o_pp = '0;
    case (w_digit)
      POS1:    o_pp = w_a1;
      POS2:    o_pp = w_a2;
      NEG1:    o_pp = '0 - w_a1;
      NEG2:    o_pp = '0 - w_a2;
      default: o_pp = '0;
    endcase
  end

endmodule

// File: rtl/radix4_booth_mult_param.sv
// Iterative radix-4 Booth multiplier: one digit per clock, start/done handshake,
// runtime signed/unsigned operand mode.
module radix4_booth_mult_param
  import radix4_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   a_in,
  input  logic [WIDTH-1:0]   b_in,
  output logic [2*WIDTH-1:0] result,
  output logic               done,
  output logic               busy
);

  localparam int EW   = even_ext_width(WIDTH);
  localparam int ITER = EW / 2;
  localparam int AW   = 2 * EW;
  localparam int CW   = $clog2(ITER) + 1;

  state_t             r_state;
  state_t             w_next_state;
  logic [EW-1:0]      r_a;
  logic [EW-1:0]      r_b;
  logic               r_bprev;
  logic [AW-1:0]      r_acc;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_result;
  logic               r_done;

  logic [EW-1:0]      w_a_ext;
  logic [EW-1:0]      w_b_ext;
  logic [2:0]         w_triplet;
  logic [EW+1:0]      w_pp;
  logic [AW-1:0]      w_pp_ext;
  logic [AW-1:0]      w_pp_shifted;
  logic               w_last;

  assign w_a_ext = is_signed ? {{(EW-WIDTH){a_in[WIDTH-1]}}, a_in}
                             : {{(EW-WIDTH){1'b0}}, a_in};
  assign w_b_ext = is_signed ? {{(EW-WIDTH){b_in[WIDTH-1]}}, b_in}
                             : {{(EW-WIDTH){1'b0}}, b_in};

  // r_b shifts right two bits per digit, so the current triplet is always at the bottom.
  assign w_triplet = {r_b[1:0], r_bprev};

  booth_r4_encoder #(
    .EW(EW)
  ) u_encoder (
    .i_triplet(w_triplet),
    .i_a_ext  (r_a),
    .o_pp     (w_pp)
  );

  assign w_pp_ext     = {{(AW-EW-2){w_pp[EW+1]}}, w_pp};
  assign w_pp_shifted = w_pp_ext << {r_count, 1'b0};
  assign w_last       = (r_count == CW'(ITER - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // New requests are taken only from IDLE; a start seen in RUN or FIN is dropped.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (start) w_next_state = RUN;
      RUN:     if (w_last) w_next_state = FIN;
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_bprev  <= 1'b0;
      r_acc    <= '0;
      r_count  <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= w_a_ext;
            r_b     <= w_b_ext;
            r_bprev <= 1'b0;
            r_acc   <= '0;
            r_count <= '0;
          end
        end
        RUN: begin
          r_acc   <= r_acc + w_pp_shifted;
          r_b     <= {2'b00, r_b[EW-1:2]};
          r_bprev <= r_b[1];
          r_count <= r_count + CW'(1);
        end
        FIN: begin
          r_result <= r_acc[2*WIDTH-1:0];
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;
  assign busy   = (r_state == RUN);

endmodule
